// File: rtl/temp_bcd_converter_seq_pkg.sv
// Shared encodings, sizes and saturation helpers for the sequential
// Celsius/Fahrenheit to BCD converter.
package temp_bcd_converter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_BCD  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int TEMP_W    = 8;
    localparam int DIV_W     = 12;
    localparam int DIV_STEPS = 12;
    localparam int BCD_STEPS = 8;

    localparam logic [7:0]       MAX_MAG        = 8'd99;
    localparam logic [DIV_W-1:0] FAHR_OFFSET_X5 = 12'd160;
    localparam logic [3:0]       DIV_LAST       = 4'd11;
    localparam logic [3:0]       BCD_LAST       = 4'd7;

    // Magnitude larger than two decimal digits can show
    function automatic logic is_over(input logic [DIV_W-1:0] mag);
        return (mag > {4'd0, MAX_MAG});
    endfunction

    // Clamp a magnitude to the two-digit display range
    function automatic logic [7:0] sat_mag(input logic [DIV_W-1:0] mag);
        logic [7:0] res;
        if (is_over(mag)) begin
            res = MAX_MAG;
        end else begin
            res = mag[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/temp_bcd_converter_seq_dabble.sv
// Sequential 8-bit binary to two-digit BCD converter: load once, then
// eight shift-add-3 steps leave the digits in the upper byte.
module bcd_dabble_8
    import temp_bcd_converter_seq_pkg::*;
(
    input  logic       clock,
    input  logic       Reset,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [15:0] shift_r;
    logic [15:0] adj_s;

    // Add 3 to each BCD nibble that would overflow past 9 on the next shift
    always_comb begin
        adj_s = shift_r;
        if (shift_r[11:8] >= 4'd5) begin
            adj_s[11:8] = shift_r[11:8] + 4'd3;
        end else begin
            adj_s[11:8] = shift_r[11:8];
        end
        if (shift_r[15:12] >= 4'd5) begin
            adj_s[15:12] = shift_r[15:12] + 4'd3;
        end else begin
            adj_s[15:12] = shift_r[15:12];
        end
    end

    // Shift register holding {tens, ones, remaining binary}
    always_ff @(posedge clock) begin
        if (!Reset) begin
            shift_r <= 16'd0;
        end else if (load) begin
            shift_r <= {8'd0, bin};
        end else if (step) begin
            shift_r <= {adj_s[14:0], 1'b0};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign tens = shift_r[15:12];
    assign ones = shift_r[11:8];

endmodule

// File: rtl/temp_bcd_converter_seq.sv
// Converts a signed Celsius sample to Fahrenheit via a restoring divider
// and presents both as sign/overflow flags plus two BCD digits each.
module temp_bcd_converter_seq
    import temp_bcd_converter_seq_pkg::*;
(
    input  logic        clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  Temperature,
    output logic [3:0]  FTens,
    output logic [3:0]  FOnes,
    output logic [3:0]  CTens,
    output logic [3:0]  COnes,
    output logic        FNeg,
    output logic        CNeg,
    output logic        FOver,
    output logic        COver,
    output logic        Busy,
    output logic        DONE
);

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [DIV_W-1:0] dividend_r;
    logic [DIV_W-1:0] quot_r;
    logic [3:0]       rem_r;
    logic             nneg_r;
    logic             cneg_r;
    logic             cover_r;
    logic [7:0]       cmag_r;
    logic             fneg_int_r;
    logic             fover_int_r;

    logic [DIV_W-1:0] temp_ext_s;
    logic [DIV_W-1:0] n_s;
    logic [DIV_W-1:0] n_abs_s;
    logic [7:0]       c_abs_s;
    logic [4:0]       rem_shift_s;
    logic [4:0]       rem_diff_s;
    logic [3:0]       rem_next_s;
    logic             q_bit_s;
    logic [DIV_W-1:0] quot_next_s;
    logic             dab_load_s;
    logic             dab_step_s;
    logic [7:0]       f_bin_s;
    logic [3:0]       f_tens_s;
    logic [3:0]       f_ones_s;
    logic [3:0]       c_tens_s;
    logic [3:0]       c_ones_s;

    // N = 9*C + 160 (i.e. 5*F), magnitudes, and one restoring-division step
    always_comb begin
        temp_ext_s  = {{(DIV_W-TEMP_W){Temperature[TEMP_W-1]}}, Temperature};
        n_s         = (temp_ext_s << 3) + temp_ext_s + FAHR_OFFSET_X5;
        n_abs_s     = n_s[DIV_W-1] ? (~n_s + 12'd1) : n_s;
        c_abs_s     = Temperature[TEMP_W-1] ? (~Temperature + 8'd1) : Temperature;
        rem_shift_s = {rem_r, dividend_r[DIV_W-1]};
        rem_diff_s  = rem_shift_s - 5'd5;
        if (rem_shift_s >= 5'd5) begin
            rem_next_s = rem_diff_s[3:0];
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem_shift_s[3:0];
            q_bit_s    = 1'b0;
        end
        quot_next_s = {quot_r[DIV_W-2:0], q_bit_s};
        f_bin_s     = sat_mag(quot_next_s);
        dab_load_s  = (state_r == ST_DIV) && (cnt_r == DIV_LAST);
        dab_step_s  = (state_r == ST_BCD);
    end

    bcd_dabble_8 u_dabble_f (
        .clock (clock),
        .Reset (Reset),
        .load  (dab_load_s),
        .step  (dab_step_s),
        .bin   (f_bin_s),
        .tens  (f_tens_s),
        .ones  (f_ones_s)
    );

    bcd_dabble_8 u_dabble_c (
        .clock (clock),
        .Reset (Reset),
        .load  (dab_load_s),
        .step  (dab_step_s),
        .bin   (cmag_r),
        .tens  (c_tens_s),
        .ones  (c_ones_s)
    );

    // Control FSM, inline divider and registered outputs
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            dividend_r  <= 12'd0;
            quot_r      <= 12'd0;
            rem_r       <= 4'd0;
            nneg_r      <= 1'b0;
            cneg_r      <= 1'b0;
            cover_r     <= 1'b0;
            cmag_r      <= 8'd0;
            fneg_int_r  <= 1'b0;
            fover_int_r <= 1'b0;
            FTens       <= 4'd0;
            FOnes       <= 4'd0;
            CTens       <= 4'd0;
            COnes       <= 4'd0;
            FNeg        <= 1'b0;
            CNeg        <= 1'b0;
            FOver       <= 1'b0;
            COver       <= 1'b0;
            Busy        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (Start) begin
                        dividend_r <= n_abs_s;
                        quot_r     <= 12'd0;
                        rem_r      <= 4'd0;
                        cnt_r      <= 4'd0;
                        nneg_r     <= n_s[DIV_W-1];
                        cneg_r     <= Temperature[TEMP_W-1];
                        cover_r    <= is_over({4'd0, c_abs_s});
                        cmag_r     <= sat_mag({4'd0, c_abs_s});
                        Busy       <= 1'b1;
                        state_r    <= ST_DIV;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                ST_DIV: begin
                    dividend_r <= {dividend_r[DIV_W-2:0], 1'b0};
                    rem_r      <= rem_next_s;
                    quot_r     <= quot_next_s;
                    if (cnt_r == DIV_LAST) begin
                        // A zero quotient is shown unsigned even when N < 0
                        fneg_int_r  <= nneg_r && (quot_next_s != 12'd0);
                        fover_int_r <= is_over(quot_next_s);
                        cnt_r       <= 4'd0;
                        state_r     <= ST_BCD;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_BCD: begin
                    if (cnt_r == BCD_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_OUT;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_OUT: begin
                    FTens   <= f_tens_s;
                    FOnes   <= f_ones_s;
                    CTens   <= c_tens_s;
                    COnes   <= c_ones_s;
                    FNeg    <= fneg_int_r;
                    CNeg    <= cneg_r;
                    FOver   <= fover_int_r;
                    COver   <= cover_r;
                    DONE    <= 1'b1;
                    Busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    Busy    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter_seq.sv
// Directed bench for temp_bcd_converter_seq with hand-computed expectations.
module tb_temp_bcd_converter_seq;

    logic       clock;
    logic       Reset;
    logic       Start;
    logic [7:0] Temperature;
    logic [3:0] FTens, FOnes, CTens, COnes;
    logic       FNeg, CNeg, FOver, COver, Busy, DONE;

    int total_cnt = 0;
    int bad_cnt   = 0;

    temp_bcd_converter_seq dut (
        .clock       (clock),
        .Reset       (Reset),
        .Start       (Start),
        .Temperature (Temperature),
        .FTens       (FTens),
        .FOnes       (FOnes),
        .CTens       (CTens),
        .COnes       (COnes),
        .FNeg        (FNeg),
        .CNeg        (CNeg),
        .FOver       (FOver),
        .COver       (COver),
        .Busy        (Busy),
        .DONE        (DONE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {FTens, FOnes, CTens, COnes};
    endfunction

    function automatic logic [3:0] flags();
        return {FNeg, CNeg, FOver, COver};
    endfunction

    // Start pulse, then checks latency, Busy length, outputs and DONE width
    task automatic convert(input string tag, input logic [7:0] t,
                           input logic [15:0] exp_dig, input logic [3:0] exp_flg);
        int  lat;
        int  busy_n;
        bit  seen;
        lat = -1; busy_n = 0; seen = 1'b0;
        @(negedge clock);
        Start = 1'b1; Temperature = t;
        @(negedge clock);
        Start = 1'b0; Temperature = 8'h5A;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (Busy) busy_n++;
            if (DONE) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                @(negedge clock);
            end
        end
        chk({tag, "_latency"}, lat, 32'd21);
        chk({tag, "_busy"}, busy_n, 32'd21);
        chk({tag, "_digits"}, {16'd0, digits()}, {16'd0, exp_dig});
        chk({tag, "_flags"}, {28'd0, flags()}, {28'd0, exp_flg});
        @(negedge clock);
        chk({tag, "_done_low"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_hold"}, {16'd0, digits()}, {16'd0, exp_dig});
    endtask

    typedef struct {
        logic [7:0]  t;
        logic [15:0] dig;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dones;
        int first_t;
        int second_t;
        logic [15:0] cap_dig;

        // {FNeg, CNeg, FOver, COver}
        vecs[0] = '{8'h19, 16'h7725, 4'b0000};  //  25C ->  77F
        vecs[1] = '{8'h00, 16'h3200, 4'b0000};  //   0C ->  32F
        vecs[2] = '{8'h25, 16'h9837, 4'b0000};  //  37C ->  98F
        vecs[3] = '{8'hD8, 16'h4040, 4'b1100};  // -40C -> -40F
        vecs[4] = '{8'hFF, 16'h3001, 4'b0100};  //  -1C ->  30F
        vecs[5] = '{8'h64, 16'h9999, 4'b0011};  // 100C -> 212F
        vecs[6] = '{8'h80, 16'h9999, 4'b1111};  // -128C -> -198F
        vecs[7] = '{8'h63, 16'h9999, 4'b0010};  //  99C -> 210F
        vecs[8] = '{8'hEE, 16'h0018, 4'b0100};  // -18C -> -2/5 -> 0F

        Reset = 1'b0; Start = 1'b0; Temperature = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_digits", {16'd0, digits()}, 32'd0);
        chk("rst_flags", {28'd0, flags()}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        Reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            convert($sformatf("vec%0d", i), vecs[i].t, vecs[i].dig, vecs[i].flg);
        end

        // Second Start five cycles into a conversion is dropped
        @(negedge clock);
        Start = 1'b1; Temperature = 8'h19;
        @(negedge clock);
        Start = 1'b0;
        repeat (4) @(negedge clock);
        Start = 1'b1; Temperature = 8'h00;
        @(negedge clock);
        Start = 1'b0;
        dones = 0; cap_dig = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            if (DONE) begin
                dones++;
                cap_dig = digits();
            end
            @(negedge clock);
        end
        chk("ignore_dones", dones, 32'd1);
        chk("ignore_digits", {16'd0, cap_dig}, 32'h0000_7725);

        // Start held high re-triggers every 22 cycles
        Start = 1'b1; Temperature = 8'h25;
        @(negedge clock);
        dones = 0; first_t = -1; second_t = -1;
        for (int n = 0; n < 70; n++) begin
            if (DONE) begin
                dones++;
                if (first_t < 0) first_t = n;
                else if (second_t < 0) second_t = n;
            end
            @(negedge clock);
        end
        Start = 1'b0;
        chk("held_dones", dones, 32'd3);
        chk("held_first", first_t, 32'd21);
        chk("held_period", second_t - first_t, 32'd22);
        chk("held_digits", {16'd0, digits()}, 32'h0000_9837);
        for (int n = 0; n < 40 && Busy; n++) @(negedge clock);
        chk("held_idle", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge clock);

        // Reset sampled at edge +10 aborts the conversion
        Start = 1'b1; Temperature = 8'hD8;
        @(negedge clock);
        Start = 1'b0;
        repeat (9) @(negedge clock);
        Reset = 1'b0;
        @(negedge clock);
        chk("abort_digits", {16'd0, digits()}, 32'd0);
        chk("abort_flags", {28'd0, flags()}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            if (DONE) dones++;
            @(negedge clock);
        end
        chk("abort_no_done", dones, 32'd0);
        chk("abort_still_zero", {16'd0, digits()}, 32'd0);
        convert("after_abort", 8'h25, 16'h9837, 4'b0000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
